// File: rtl/add_arb_pkg.sv
// Shared definitions for the add_arb slice: output-stage states, id width,
// default geometry and the round-robin pointer advance helper.
package add_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;
  localparam int ID_W      = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Pointer moves one past the last winner, wrapping at nreq-1
  function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] idx,
                                                 input int nreq);
    if (int'(idx) >= nreq - 1) begin
      return '0;
    end
    return idx + ID_W'(1);
  endfunction

endpackage

// File: rtl/add_rr_pick.sv
// Combinational round-robin picker: first asserted valid at or after ptr,
// wrapping NREQ-1 -> 0; returns one-hot grant, binary index and a found flag.
module add_rr_pick
  import add_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] index,
  output logic            found
);

  logic [ID_W:0] pos;

  // Walk offsets 0..NREQ-1 from ptr; the first valid slot hit wins
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(k);
      if (pos >= (ID_W+1)'(NREQ)) begin
        pos = pos - (ID_W+1)'(NREQ);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && valid[i] && (pos == (ID_W+1)'(i))) begin
          grant[i] = 1'b1;
          index    = ID_W'(i);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/add_arb.sv
// Round-robin arbitrated shared adder with a single registered result stage.
// Define ADD_ARB_SAT_EN to saturate rsp_sum to all-ones on carry-out.
module add_arb
  import add_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic [ID_W-1:0]       rsp_id
);

  out_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  gidx;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] load_sum;

  add_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .index (gidx),
    .found (found)
  );

  // One-hot grant makes an AND-OR operand mux sufficient
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
        sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, sel_a} + {1'b0, sel_b};

`ifdef ADD_ARB_SAT_EN
  assign load_sum = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
  assign load_sum = sum_full[WIDTH-1:0];
`endif

  // A held result can be replaced in the same cycle it is being drained
  always_comb begin
    state_d    = state_q;
    can_accept = 1'b0;
    case (state_q)
      EMPTY:   can_accept = 1'b1;
      FULL:    can_accept = rsp_ready;
      default: can_accept = 1'b0;
    endcase
    accept    = found & can_accept;
    req_ready = grant & {NREQ{can_accept}};
    if (accept) begin
      state_d = FULL;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  assign rsp_valid = (state_q == FULL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_sum   <= load_sum;
        rsp_carry <= sum_full[WIDTH];
        rsp_id    <= gidx;
        ptr_q     <= next_index(gidx, NREQ);
      end
    end
  end

endmodule

// File: tb/tb_add_arb.sv
// Directed bench for add_arb (WIDTH=32, NREQ=4) followed by a model-checked
// random phase; honours ADD_ARB_SAT_EN for expected overflow sums.
module tb_add_arb;

  localparam int W = 32;
  localparam int N = 4;

`ifdef ADD_ARB_SAT_EN
  localparam logic [W-1:0] OVF_SUM = 32'hFFFF_FFFF;
  localparam bit           SAT     = 1'b1;
`else
  localparam logic [W-1:0] OVF_SUM = 32'h0000_0000;
  localparam bit           SAT     = 1'b0;
`endif

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic [2:0]     rsp_id;

  int checks   = 0;
  int failures = 0;

  add_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
  endtask

  task automatic setOperands(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Random-phase reference state
  bit           modelFull;
  int           modelPtr;
  logic [W-1:0] expSum;
  logic         expCarry;
  logic [2:0]   expId;
  logic [N-1:0] accMask;
  logic [N-1:0] pending;
  logic [N-1:0] expReady;
  int           g;
  logic [W:0]   wide;

  initial begin
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    applyStimulus('0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_valid", rsp_valid, 0);
    checkOutput("reset_sum",   rsp_sum,   0);
    checkOutput("reset_carry", rsp_carry, 0);
    checkOutput("reset_id",    rsp_id,    0);
    @(negedge clock);
    reset = 1'b0;

    // Single request from requester 0
    setOperands(0, 32'd23, 32'd34);
    applyStimulus(4'b0001, 1'b1);
    #1;
    checkOutput("first_ready", req_ready, 4'b0001);
    tick();
    checkOutput("first_valid", rsp_valid, 1);
    checkOutput("first_sum",   rsp_sum,   57);
    checkOutput("first_carry", rsp_carry, 0);
    checkOutput("first_id",    rsp_id,    0);

    // Overflow on requester 1, refilled while draining
    setOperands(1, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'b0010, 1'b1);
    #1;
    checkOutput("ovf_ready", req_ready, 4'b0010);
    tick();
    checkOutput("ovf_sum",   rsp_sum,   OVF_SUM);
    checkOutput("ovf_carry", rsp_carry, 1);
    checkOutput("ovf_id",    rsp_id,    1);

    // No requests: drain, result fields retained
    applyStimulus(4'b0000, 1'b1);
    #1;
    checkOutput("idle_ready", req_ready, 4'b0000);
    tick();
    checkOutput("drain_valid", rsp_valid, 0);
    checkOutput("drain_sum",   rsp_sum,   OVF_SUM);
    checkOutput("drain_id",    rsp_id,    1);

    // Fresh reset, then all four requesting: ids 0,1,2,3,0 back to back
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) setOperands(i, 32'(100 + i), 32'(10 * i));
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("rr_ready%0d", k), req_ready, 4'b0001 << (k % 4));
      tick();
      checkOutput($sformatf("rr_valid%0d", k), rsp_valid, 1);
      checkOutput($sformatf("rr_id%0d", k),    rsp_id,    k % 4);
      checkOutput($sformatf("rr_sum%0d", k),   rsp_sum,   100 + 11 * (k % 4));
    end

    // Back-pressure: everything frozen, nothing granted
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput($sformatf("stall_ready%0d", k), req_ready, 4'b0000);
      tick();
      checkOutput($sformatf("stall_valid%0d", k), rsp_valid, 1);
      checkOutput($sformatf("stall_sum%0d", k),   rsp_sum,   100);
      checkOutput($sformatf("stall_id%0d", k),    rsp_id,    0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("unstall_ready", req_ready, 4'b0010);
    tick();
    checkOutput("unstall_id",  rsp_id,  1);
    checkOutput("unstall_sum", rsp_sum, 111);

    // Asynchronous reset while FULL with ptr=2
    req_valid = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", rsp_valid, 0);
    checkOutput("async_sum",   rsp_sum,   0);
    checkOutput("async_id",    rsp_id,    0);
    reset = 1'b0;
    applyStimulus(4'b1100, 1'b1);
    #1;
    checkOutput("post_rst_ready", req_ready, 4'b0100);
    tick();
    checkOutput("post_rst_id",  rsp_id,  2);
    checkOutput("post_rst_sum", rsp_sum, 122);
    #1;
    checkOutput("post_rst_ready2", req_ready, 4'b1000);
    tick();
    checkOutput("post_rst_id2",  rsp_id,  3);
    checkOutput("post_rst_sum2", rsp_sum, 133);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("final_drain", rsp_valid, 0);

    // Random traffic against a reference model
    modelFull = 1'b0;
    modelPtr  = 0;
    expSum    = rsp_sum;
    expCarry  = rsp_carry;
    expId     = rsp_id;
    accMask   = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clock);
      pending = req_valid & ~accMask;
      for (int i = 0; i < N; i++) begin
        if (!pending[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          setOperands(i, $urandom(), $urandom());
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(modelPtr + k) % N]) g = (modelPtr + k) % N;
      end
      expReady = '0;
      if (g >= 0 && (!modelFull || rsp_ready)) expReady[g] = 1'b1;
      checkOutput("rnd_ready", req_ready, expReady);
      tick();
      if (expReady != '0) begin
        wide      = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
        expCarry  = wide[W];
        expSum    = (SAT && wide[W]) ? {W{1'b1}} : wide[W-1:0];
        expId     = 3'(g);
        modelFull = 1'b1;
        modelPtr  = (g + 1) % N;
      end else if (rsp_ready) begin
        modelFull = 1'b0;
      end
      accMask = expReady;
      checkOutput("rnd_valid", rsp_valid, modelFull);
      checkOutput("rnd_sum",   rsp_sum,   expSum);
      checkOutput("rnd_carry", rsp_carry, expCarry);
      checkOutput("rnd_id",    rsp_id,    expId);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
